// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - BIP sequencer/decoder: fetch/exec FSM, opcode decode, halt.
// Optional cycle counter output enabled by BIP_CYCLE_COUNTER_EN.
module bip_control_unit #(
    parameter int                  PC_WIDTH    = 11,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic [INSTR_WIDTH-1:0] Instr,
    output logic [PC_WIDTH-1:0]    PcAddr,
    output logic [PC_WIDTH-1:0]    Operand,
    output logic [1:0]             SelA,
    output logic                   SelB,
    output logic                   Op,
    output logic                   WrAcc,
    output logic                   WrRam,
    output logic                   RdRam,
`ifdef BIP_CYCLE_COUNTER_EN
    output logic [15:0]            CycleCount,
`endif
    output logic                   Halted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

    logic [1:0]             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [4:0]             opcode;
    logic                   start_ok;

    assign opcode   = ir_q[INSTR_WIDTH-1 -: 5];
    assign start_ok = Start && (state_q == ST_IDLE || state_q == ST_HALT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
                ir_d    = Instr;
            end
            ST_EXEC: begin
                if (opcode == OPC_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Decode is combinational from the state register so an async reset clears every strobe at once.
    always_comb begin
        Operand = '0;
        SelA    = 2'd0;
        SelB    = 1'b0;
        Op      = 1'b0;
        WrAcc   = 1'b0;
        WrRam   = 1'b0;
        RdRam   = 1'b0;
        if (state_q == ST_EXEC) begin
            Operand = ir_q[PC_WIDTH-1:0];
            case (opcode)
                OPC_STO:  WrRam = 1'b1;
                OPC_LD:   begin RdRam = 1'b1; SelA = 2'd0; WrAcc = 1'b1; end
                OPC_LDI:  begin SelA = 2'd1; WrAcc = 1'b1; end
                OPC_ADD:  begin RdRam = 1'b1; SelB = 1'b0; Op = 1'b0; SelA = 2'd2; WrAcc = 1'b1; end
                OPC_ADDI: begin SelB = 1'b1; Op = 1'b0; SelA = 2'd2; WrAcc = 1'b1; end
                OPC_SUB:  begin RdRam = 1'b1; SelB = 1'b0; Op = 1'b1; SelA = 2'd2; WrAcc = 1'b1; end
                OPC_SUBI: begin SelB = 1'b1; Op = 1'b1; SelA = 2'd2; WrAcc = 1'b1; end
                default:  ;
            endcase
        end
    end

    assign PcAddr = pc_q;
    assign Halted = (state_q == ST_HALT);

`ifdef BIP_CYCLE_COUNTER_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_ok)
            cnt_d = '0;
        else if ((state_q == ST_FETCH || state_q == ST_EXEC) && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign CycleCount = cnt_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule
